// File: rtl/display_scanner.sv
// Time-multiplexed seven-segment digit scanner: rotates through a frame-shadowed
// hex value, driving one active-low anode and the digit nibble/sign per slot.
module display_scanner #(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int LZ_BLANK    = 1,
  localparam int IW = $clog2(DIGITS),
  localparam int CW = $clog2(REFRESH_DIV)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic                  sign_in,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic                  load_req,
  output logic                  load_ack,
  output logic [3:0]            num,
  output logic                  sign_out,
  output logic [DIGITS-1:0]     anode_n,
  output logic [IW-1:0]         digit_idx
);

  logic [CW-1:0]       r_div_cnt;
  logic [IW-1:0]       r_digit_idx;
  logic                r_pending;
  logic [4*DIGITS-1:0] r_shadow;
  logic                r_sign;
  logic [3:0]          r_num;
  logic                r_sign_out;
  logic [DIGITS-1:0]   r_anode_n;

  logic                w_tick;
  logic                w_last;
  logic                w_load;
  logic [IW-1:0]       w_idx_nxt;
  logic [4*DIGITS-1:0] w_shadow_nxt;
  logic                w_sign_nxt;
  logic [3:0]          w_num_nxt;
  logic [DIGITS-1:0]   w_anode_nxt;
  logic [DIGITS-1:0]   w_blank;
  logic                w_upper_nz;

  assign w_tick       = (r_div_cnt == CW'(REFRESH_DIV - 1));
  assign w_last       = (r_digit_idx == IW'(DIGITS - 1));
  assign w_load       = w_tick & w_last & (r_pending | load_req);
  assign w_idx_nxt    = w_tick ? (w_last ? '0 : r_digit_idx + 1'b1) : r_digit_idx;
  assign w_shadow_nxt = w_load ? value_in : r_shadow;
  assign w_sign_nxt   = w_load ? sign_in : r_sign;

  // Display outputs are built from next-state index/shadow so they register
  // on the same edge as digit_idx; a digit is lead-zero if it and all above are 0.
  always_comb begin
    w_upper_nz  = 1'b0;
    w_blank     = '0;
    w_num_nxt   = '0;
    w_anode_nxt = '1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_upper_nz = w_upper_nz | (w_shadow_nxt[4*k +: 4] != 4'h0);
      w_blank[k] = blank_mask[k] | ((LZ_BLANK != 0) && (k > 0) && !w_upper_nz);
      if (IW'(k) == w_idx_nxt) begin
        w_num_nxt      = w_shadow_nxt[4*k +: 4];
        w_anode_nxt[k] = w_blank[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt   <= '0;
      r_digit_idx <= '0;
      r_pending   <= 1'b0;
      r_shadow    <= '0;
      r_sign      <= 1'b0;
      r_num       <= '0;
      r_sign_out  <= 1'b0;
      r_anode_n   <= '1;
    end else begin
      r_div_cnt   <= w_tick ? '0 : r_div_cnt + 1'b1;
      r_digit_idx <= w_idx_nxt;
      r_shadow    <= w_shadow_nxt;
      r_sign      <= w_sign_nxt;
      if (w_load)
        r_pending <= 1'b0;
      else if (load_req)
        r_pending <= 1'b1;
      r_num      <= w_num_nxt;
      r_sign_out <= (w_idx_nxt == IW'(DIGITS - 1)) & w_sign_nxt;
      r_anode_n  <= w_anode_nxt;
    end
  end

  assign load_ack  = w_load;
  assign num       = r_num;
  assign sign_out  = r_sign_out;
  assign anode_n   = r_anode_n;
  assign digit_idx = r_digit_idx;

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner (4 digits, 4-cycle refresh): directed and random
// stimulus compared each cycle against a cycle-count based display model.
module tb_display_scanner;
  localparam int D  = 4;
  localparam int R  = 4;
  localparam int FR = D * R;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value_in = '0;
  logic        sign_in = 1'b0;
  logic [3:0]  blank_mask = '0;
  logic        load_req = 1'b0;
  logic        load_ack;
  logic [3:0]  num;
  logic        sign_out;
  logic [3:0]  anode_n;
  logic [1:0]  digit_idx;

  display_scanner #(.DIGITS(D), .REFRESH_DIV(R), .LZ_BLANK(1)) dut (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .sign_in(sign_in),
    .blank_mask(blank_mask), .load_req(load_req), .load_ack(load_ack),
    .num(num), .sign_out(sign_out), .anode_n(anode_n), .digit_idx(digit_idx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int ack_cnt = 0;

  // Model: m_s counts clock edges since reset release; everything else follows.
  int          m_s;
  logic [15:0] m_sh;
  logic        m_sg;
  logic        m_pend;
  logic [3:0]  m_anode;
  logic [3:0]  m_num;
  logic        m_sign;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s = 0; m_sh = '0; m_sg = 1'b0; m_pend = 1'b0;
    m_anode = 4'hF; m_num = '0; m_sign = 1'b0;
  endtask

  task automatic model_edge();
    int d;
    logic blanked;
    if ((m_s % FR) == FR - 1 && (m_pend || load_req)) begin
      m_sh = value_in; m_sg = sign_in; m_pend = 1'b0;
    end else if (load_req) begin
      m_pend = 1'b1;
    end
    m_s++;
    d = (m_s / R) % D;
    m_num = 4'((m_sh >> (4 * d)) & 16'hF);
    blanked = blank_mask[d] || (d > 0 && (m_sh >> (4 * d)) == 16'h0);
    m_anode = blanked ? 4'hF : ~(4'b0001 << d);
    m_sign = (d == D - 1) ? m_sg : 1'b0;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".idx"}, 32'(digit_idx), 32'((m_s / R) % D));
    chk({tag, ".anode_n"}, 32'(anode_n), 32'(m_anode));
    chk({tag, ".num"}, 32'(num), 32'(m_num));
    chk({tag, ".sign_out"}, 32'(sign_out), 32'(m_sign));
    chk({tag, ".load_ack"}, 32'(load_ack),
        32'(((m_s % FR) == FR - 1) && (m_pend || load_req)));
  endtask

  // Called at a falling edge with inputs already set for this cycle.
  task automatic step(input string tag);
    #1 check_outs(tag);
    if (load_ack === 1'b1) ack_cnt++;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Blank display after reset: only digit 0 lit, no acks.
    run("idle", FR);
    chk("idle.acks", 32'(ack_cnt), 32'd0);

    // Pulse request early in the frame; load happens at frame end.
    ack_cnt = 0;
    run("a05c", 2);
    value_in = 16'hA05C; sign_in = 1'b1; load_req = 1'b1;
    step("a05c");
    load_req = 1'b0;
    run("a05c", 2 * FR - 3);
    chk("a05c.acks", 32'(ack_cnt), 32'd1);

    value_in = 16'h0030; sign_in = 1'b0; load_req = 1'b1;
    step("lz");
    load_req = 1'b0;
    run("lz", 2 * FR - 1);

    value_in = 16'h1234; blank_mask = 4'b0010; load_req = 1'b1;
    step("mask");
    load_req = 1'b0;
    run("mask", 2 * FR - 1);
    blank_mask = 4'b0000;

    // Request held across three frames with the value changing each frame.
    ack_cnt = 0;
    load_req = 1'b1;
    for (int f = 1; f <= 3; f++) begin
      value_in = 16'h1111 * 16'(f);
      run("held", FR);
    end
    load_req = 1'b0;
    run("held", FR);
    chk("held.acks", 32'(ack_cnt), 32'd3);

    for (int i = 0; i < 10 * FR; i++) begin
      load_req   = ($urandom_range(0, 7) == 0);
      value_in   = 16'($urandom);
      sign_in    = 1'($urandom_range(0, 1));
      blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      step("rand");
    end
    load_req = 1'b0; blank_mask = 4'b0000;

    // Reset mid-frame with a request pending: request is dropped.
    value_in = 16'h9876; sign_in = 1'b1;
    run("mid", 2);
    load_req = 1'b1;
    step("mid");
    load_req = 1'b0;
    run("mid", 2);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_outs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    ack_cnt = 0;
    run("post_rst", 2 * FR);
    chk("post_rst.acks", 32'(ack_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
